// File: rtl/led_pattern_pwm_if.sv
// Control and status bundle between the LED pattern source and its controller.
// step_tick is a one-cycle strobe that marks a pattern step; there is no back-pressure.
interface led_pattern_pwm_if;
    logic [1:0] mode;
    logic [2:0] brightness;
    logic       pause;
    logic       step_tick;
    logic [7:0] pattern;
    logic [7:0] led_n;

    modport master (
        output mode, brightness, pause,
        input  step_tick, pattern, led_n
    );

    modport slave (
        input  mode, brightness, pause,
        output step_tick, pattern, led_n
    );
endinterface

// File: rtl/led_pattern_pwm.sv
// LED pattern generator: count/scan/all-on/hold patterns stepped by a prescaler,
// gated by a 3-bit PWM and registered as an active-low drive vector.
module led_pattern_pwm #(
    parameter int CLK_HZ  = 12_000_000,
    parameter int STEP_HZ = 16
) (
    input  logic             clk_12mhz,
    input  logic             rst,
    led_pattern_pwm_if.slave bus
);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int PW  = $clog2(DIV);
    localparam logic [PW-1:0] RELOAD = PW'(DIV - 1);

    if (DIV < 2 || (CLK_HZ % STEP_HZ) != 0) begin : g_div_check
        $error("led_pattern_pwm: CLK_HZ/STEP_HZ must be an integer >= 2");
    end

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_ALL   = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic [7:0]    r_pattern;
    logic [2:0]    r_scan_pos;
    dir_e          r_scan_dir;
    mode_e         r_mode_q;
    logic          r_restart;
    logic [2:0]    r_pwm_cnt;
    logic [2:0]    r_bright;
    logic [7:0]    r_led_n;

    logic [PW-1:0] w_presc_nxt;
    logic          w_tick_nxt;
    logic [7:0]    w_pattern_nxt;
    logic [2:0]    w_pos_nxt;
    dir_e          w_dir_nxt;
    logic [2:0]    w_pos_step;
    logic          w_mode_chg;
    logic          w_pwm_on;

    assign w_mode_chg = (bus.mode != r_mode_q);
    assign w_pwm_on   = (r_pwm_cnt <= r_bright);
    assign w_pos_step = (r_scan_dir == DIR_UP) ? r_scan_pos + 3'd1 : r_scan_pos - 3'd1;

    // A mode change detected this cycle drops any tick due now; the restart
    // itself is applied one cycle later using the freshly registered mode.
    always_comb begin
        w_presc_nxt   = r_presc;
        w_tick_nxt    = 1'b0;
        w_pattern_nxt = r_pattern;
        w_pos_nxt     = r_scan_pos;
        w_dir_nxt     = r_scan_dir;
        if (r_restart) begin
            w_presc_nxt = RELOAD;
            w_pos_nxt   = 3'd0;
            w_dir_nxt   = DIR_UP;
            case (r_mode_q)
                MODE_COUNT: w_pattern_nxt = 8'h00;
                MODE_SCAN:  w_pattern_nxt = 8'h01;
                MODE_ALL:   w_pattern_nxt = 8'hFF;
                default:    w_pattern_nxt = r_pattern;
            endcase
        end else begin
            if (!bus.pause) begin
                if (r_presc == '0) begin
                    w_presc_nxt = RELOAD;
                    w_tick_nxt  = !w_mode_chg;
                end else begin
                    w_presc_nxt = r_presc - PW'(1);
                end
            end
            if (r_tick) begin
                case (r_mode_q)
                    MODE_COUNT: w_pattern_nxt = r_pattern + 8'd1;
                    MODE_SCAN: begin
                        w_pos_nxt     = w_pos_step;
                        w_pattern_nxt = 8'd1 << w_pos_step;
                        if (w_pos_step == 3'd7) begin
                            w_dir_nxt = DIR_DOWN;
                        end else if (w_pos_step == 3'd0) begin
                            w_dir_nxt = DIR_UP;
                        end
                    end
                    MODE_ALL:   w_pattern_nxt = 8'hFF;
                    default:    w_pattern_nxt = r_pattern;
                endcase
            end
        end
    end

    always_ff @(posedge clk_12mhz) begin
        if (rst) begin
            r_presc    <= RELOAD;
            r_tick     <= 1'b0;
            r_pattern  <= 8'h00;
            r_scan_pos <= 3'd0;
            r_scan_dir <= DIR_UP;
            r_mode_q   <= MODE_COUNT;
            r_restart  <= 1'b0;
            r_pwm_cnt  <= 3'd0;
            r_bright   <= 3'd0;
            r_led_n    <= 8'hFF;
        end else begin
            r_presc    <= w_presc_nxt;
            r_tick     <= w_tick_nxt;
            r_pattern  <= w_pattern_nxt;
            r_scan_pos <= w_pos_nxt;
            r_scan_dir <= w_dir_nxt;
            r_mode_q   <= mode_e'(bus.mode);
            r_restart  <= w_mode_chg;
            r_pwm_cnt  <= r_pwm_cnt + 3'd1;
            // Duty only changes at the period boundary so a window is never split.
            if (r_pwm_cnt == 3'd7) begin
                r_bright <= bus.brightness;
            end
            r_led_n    <= ~(r_pattern & {8{w_pwm_on}});
        end
    end

    assign bus.step_tick = r_tick;
    assign bus.pattern   = r_pattern;
    assign bus.led_n     = r_led_n;
endmodule

// File: doc/led_pattern_pwm.md
# led_pattern_pwm

Upstream pattern source for the CertusPro-NX evaluation board LED path. Generates an 8-bit LED pattern (binary count, bouncing scan, all-on, or hold), stepped at a programmable rate and brightness-modulated by a 3-bit PWM. Produces the active-low, registered `led_n` vector. That vector feeds the LED output register stage, which places the final flops in the I/O cells, directly.

## Interface

- `CLK_HZ`, default 12_000_000: input clock frequency in Hz.
- `STEP_HZ`, default 16: pattern step rate in Hz. `DIV = CLK_HZ/STEP_HZ` is an integer ≥ 2; enforce with an elaboration check.

- `clk_12mhz`  in  1  board 12 MHz clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  pattern select: 0 = binary up-count, 1 = bouncing scan, 2 = all-on, 3 = hold (freeze current pattern).
- `brightness`  in  3  PWM duty code; duty = (brightness+1)/8.
- `pause`  in  1  when high, the step prescaler is frozen; PWM keeps running.
- `step_tick`  out  1  one-cycle pulse on each pattern step.
- `pattern`  out  8  current active-high pattern; debug and status use.
- `led_n`  out  8  active-low, PWM-gated LED drive to the output register stage.

## Operation

- **Reset values** (`rst` high at a clock edge):
  - `led_n` = 8'hFF
  - `pattern` = 8'h00
  - `step_tick` = 0
  - prescaler = DIV-1
  - PWM counter = 0
  - brightness register = 0
  - scan position = 0, direction up
  - `mode_q` = 0
- **Prescaler:**
  - Down-counter from DIV-1 to 0, decrementing each cycle when `pause`=0.
  - At 0 with `pause`=0: `step_tick` is asserted next cycle and the counter reloads DIV-1.
  - `pause`=1 holds the count and suppresses ticks.
- **Mode change:**
  - `mode` is registered into `mode_q` every cycle.
  - If `mode` ≠ `mode_q`, the next cycle restarts: prescaler = DIV-1, binary count = 0, scan position 0 direction up.
  - Pattern is loaded from the new mode's initial value: mode 0 → 8'h00, mode 1 → 8'h01, mode 2 → 8'hFF, mode 3 → unchanged.
  - A restart cycle does not emit `step_tick`.
- **Step, applied on the cycle `step_tick` is high:**
  - Mode 0: pattern <= pattern+1, modulo 256 (8'hFF → 8'h00).
  - Mode 1: one-hot at the scan position. Position moves 0→7, then 6→0, then repeats, for a 14-step period. Direction reverses when the position reaches 7 (up) or 0 (down). Neither endpoint is repeated.
  - Mode 2: pattern stays 8'hFF.
  - Mode 3: pattern unchanged. `step_tick` still pulses.
- **PWM:**
  - 3-bit free-running counter, wraps 7→0, never paused.
  - The brightness register loads from `brightness` only in the cycle the counter wraps 7→0, so the duty never glitches mid-period.
  - `pwm_on` = (pwm counter ≤ brightness register).
- **Output:** `led_n` <= ~(pattern & {8{pwm_on}}), registered.
- **Simultaneous events:**
  - `rst` overrides everything.
  - A mode change in the same cycle a tick would occur takes priority; the tick is dropped.
  - `pause` asserted on the prescaler's 0 cycle suppresses that tick.

## Timing

- `step_tick` period is exactly DIV cycles with `pause` low and `mode` constant.
- First tick after reset deassertion: DIV cycles after the first non-reset edge.
- `pattern` updates on the same edge that `step_tick` is observed high.
- `led_n` lags `pattern` and `pwm_on` by 1 cycle.
- Brightness change latency: up to 8 cycles (next PWM wrap) plus 1 output cycle.
- Mode change:
  - `mode_q` updates 1 cycle after `mode`.
  - Pattern reload occurs 1 cycle later.
  - `led_n` reflects it 1 further cycle later.
- PWM period is 8 cycles. At brightness 7, `led_n` is continuously ~pattern. At brightness 0, each set bit is low 1 of every 8 cycles (12.5%).

## Test plan

Bench uses CLK_HZ=64, STEP_HZ=4 (DIV=16).

1. **Reset mid-operation:** mode 0, run 100 cycles, assert `rst` for 1 cycle. Expect `led_n`=8'hFF and `pattern`=0 the next cycle, and the first `step_tick` exactly 16 cycles after release.
2. **Binary wrap:** mode 0, brightness 7, run 257 ticks. Expect `pattern` to go 8'hFF→8'h00 on tick 256, and `led_n` = ~pattern one cycle after each step.
3. **Scan bounce:** mode 1, 15 ticks. Expect pattern sequence 01,02,04,08,10,20,40,80,40,20,10,08,04,02,01, with no repeated 80 or 01 at the turnarounds.
4. **PWM duty:** mode 2, sweep brightness 0..7, 64 cycles each. Count `led_n`==8'h00 cycles per 8-cycle window: expect brightness+1. A brightness change mid-window takes effect only at the next wrap.
5. **Pause and tick spacing:** `pause` high for 40 cycles mid-count. Expect no ticks; the remaining count resumes unchanged, and total tick spacing equals 16+40 cycles.
6. **Mode change racing a tick:** change mode 0→1 on the prescaler's 0 cycle. Expect no tick, `pattern`=8'h01 two cycles later, and the next tick 16 cycles after the restart.
